reg_write_arbiter: RTL and testbench

Round-robin arbiter that shares one DATA_W-bit register among N_REQ requesters. Each cycle at most one pending requester wins and its data is captured into the shared register. A registered one-hot grant acknowledges the write. The block sits in front of the team's shared state registers, so several control paths can update one flop bank without contention.

---
 rtl/reg_write_arbiter_if.sv | 26 ++
 rtl/reg_write_arbiter.sv | 117 +++++++++++
 tb/tb_reg_write_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_write_arbiter_if.sv
// Requester-side bundle for reg_write_arbiter. The lock vector exists only when
// ARB_LOCK_EN is defined.
interface reg_write_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned OwnerW = $clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] wdata;
`ifdef ARB_LOCK_EN
  logic [N_REQ-1:0]        lock;
`endif
  logic [N_REQ-1:0]        gnt;
  logic [DATA_W-1:0]       q;
  logic [OwnerW-1:0]       owner;
  logic                    q_valid;

`ifdef ARB_LOCK_EN
  modport master (output req, wdata, lock, input gnt, q, owner, q_valid);
  modport slave  (input req, wdata, lock, output gnt, q, owner, q_valid);
`else
  modport master (output req, wdata, input gnt, q, owner, q_valid);
  modport slave  (input req, wdata, output gnt, q, owner, q_valid);
`endif
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter writing one shared DATA_W-bit register from N_REQ requesters.
// Optional bus locking is compiled in with the ARB_LOCK_EN macro.
module reg_write_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 8
) (
  input logic                clk,
  input logic                reset,
  reg_write_arbiter_if.slave arb_bus
);
  localparam int unsigned     OwnerW = $clog2(N_REQ);
  localparam logic [OwnerW:0] NReqW  = (OwnerW + 1)'(N_REQ);

  logic [N_REQ-1:0]  r_gnt;
  logic [DATA_W-1:0] r_q;
  logic [OwnerW-1:0] r_owner;
  logic [OwnerW-1:0] r_ptr;
  logic              r_q_valid;

  logic [N_REQ-1:0]  w_elig;
  logic [N_REQ-1:0]  w_onehot;
  logic [OwnerW:0]   w_idx;
  logic [OwnerW-1:0] w_win;
  logic [OwnerW-1:0] w_ptr_next;
  logic              w_found;
  logic              w_upd_ptr;
  logic [DATA_W-1:0] w_data [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_data[g] = arb_bus.wdata[g*DATA_W +: DATA_W];
  end

`ifdef ARB_LOCK_EN
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]        r_state;
  logic [OwnerW-1:0] r_lock_id;
  logic              w_lock_hold;

  // Lock persists only while the owner keeps its lock bit high.
  assign w_lock_hold = (r_state == ST_LOCKED) && arb_bus.lock[r_lock_id];
  assign w_upd_ptr   = ~w_lock_hold;

  always_comb begin
    w_elig = arb_bus.req & ~r_gnt;
    if (w_lock_hold) begin
      w_elig = w_elig & (N_REQ'(1) << r_lock_id);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_lock_id <= '0;
    end else if (!w_lock_hold) begin
      if (w_found && arb_bus.lock[w_win]) begin
        r_state   <= ST_LOCKED;
        r_lock_id <= w_win;
      end else begin
        r_state   <= ST_IDLE;
      end
    end
  end
`else
  assign w_upd_ptr = 1'b1;

  always_comb begin
    w_elig = arb_bus.req & ~r_gnt;
  end
`endif

  // Scan from r_ptr upward, wrapping, first eligible index wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_idx = {1'b0, r_ptr} + (OwnerW + 1)'(i);
      if (w_idx >= NReqW) begin
        w_idx = w_idx - NReqW;
      end
      if (!w_found && w_elig[w_idx[OwnerW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[OwnerW-1:0];
      end
    end
  end

  assign w_onehot   = N_REQ'(1) << w_win;
  assign w_ptr_next = (w_win == OwnerW'(N_REQ - 1)) ? '0 : w_win + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt     <= '0;
      r_q       <= '0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_q_valid <= 1'b0;
    end else begin
      r_gnt <= w_found ? w_onehot : '0;
      if (w_found) begin
        r_q       <= w_data[w_win];
        r_owner   <= w_win;
        r_q_valid <= 1'b1;
        if (w_upd_ptr) begin
          r_ptr <= w_ptr_next;
        end
      end
    end
  end

  assign arb_bus.gnt     = r_gnt;
  assign arb_bus.q       = r_q;
  assign arb_bus.owner   = r_owner;
  assign arb_bus.q_valid = r_q_valid;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed vectors, a per-cycle reference model and
// literal expectations. Lock scenarios run only when ARB_LOCK_EN is defined.
module tb_reg_write_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  reg_write_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();

  reg_write_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .arb_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: state after each edge, derived from the arbitration rules.
  logic [N-1:0] m_gnt;
  logic [W-1:0] m_q;
  logic [1:0]   m_owner;
  logic         m_valid;
  int           m_ptr;
  bit           m_locked;
  int           m_lock_id;

  always @(posedge clk or posedge reset) begin : model
    int           win;
    int           idx;
    bit           hold;
    logic [N-1:0] elig;
    if (reset) begin
      m_gnt = '0; m_q = '0; m_owner = '0; m_valid = 1'b0;
      m_ptr = 0; m_locked = 1'b0; m_lock_id = 0;
    end else begin
      elig = bus.req & ~m_gnt;
      hold = 1'b0;
`ifdef ARB_LOCK_EN
      hold = m_locked && bus.lock[m_lock_id];
      if (hold) elig = elig & (N'(1) << m_lock_id);
`endif
      win = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (win < 0 && elig[idx]) win = idx;
      end
      m_gnt = '0;
      if (win >= 0) begin
        m_gnt   = N'(1) << win;
        m_q     = bus.wdata[win*W +: W];
        m_owner = 2'(win);
        m_valid = 1'b1;
        if (!hold) m_ptr = (win + 1) % N;
      end
`ifdef ARB_LOCK_EN
      if (!hold) begin
        m_locked = (win >= 0) && bus.lock[win];
        if (m_locked) m_lock_id = win;
      end
`endif
    end
  end

  always @(negedge clk) begin
    n_checks++;
    if (bus.gnt !== m_gnt || bus.q !== m_q || bus.owner !== m_owner ||
        bus.q_valid !== m_valid) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t gnt=%b/%b q=%h/%h owner=%0d/%0d q_valid=%b/%b (dut/model)",
               $time, bus.gnt, m_gnt, bus.q, m_q, bus.owner, m_owner, bus.q_valid, m_valid);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_data(input int idx, input logic [W-1:0] d);
    bus.wdata[idx*W +: W] = d;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [N-1:0] pats [10] = '{4'b0101, 4'b0110, 4'b1111, 4'b0011, 4'b1100,
                              4'b1010, 4'b0111, 4'b1110, 4'b0000, 4'b1001};

  initial begin
    reset    = 1'b1;
    bus.req  = '0;
    bus.wdata = '0;
`ifdef ARB_LOCK_EN
    bus.lock = '0;
`endif
    tick(); tick();
    chk("reset_gnt", 32'(bus.gnt), 0);
    chk("reset_q", 32'(bus.q), 0);
    chk("reset_owner", 32'(bus.owner), 0);
    chk("reset_qvalid", 32'(bus.q_valid), 0);
    #2 reset = 1'b0;

    // Write 0xAA, then reset mid-cycle while gnt is still high.
    set_data(0, 8'hAA);
    bus.req = 4'b0001;
    tick();
    chk("write_aa_gnt", 32'(bus.gnt), 32'h1);
    chk("write_aa_q", 32'(bus.q), 32'hAA);
    chk("write_aa_qvalid", 32'(bus.q_valid), 1);
    bus.req = '0;
    #1 reset = 1'b1;
    #1;
    chk("async_rst_q", 32'(bus.q), 0);
    chk("async_rst_gnt", 32'(bus.gnt), 0);
    chk("async_rst_owner", 32'(bus.owner), 0);
    chk("async_rst_qvalid", 32'(bus.q_valid), 0);
    #2 reset = 1'b0;

    // Single continuous requester: grants every other edge.
    set_data(2, 8'h5C);
    bus.req = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("single_gnt%0d", k), 32'(bus.gnt), (k % 2 == 0) ? 32'h4 : 32'h0);
      chk($sformatf("single_q%0d", k), 32'(bus.q), 32'h5C);
    end
    bus.req = '0;
    tick();

    // Full contention from a fresh pointer.
    reset_pulse();
    for (int i = 0; i < N; i++) set_data(i, 8'(8'h10 + i));
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rr_gnt%0d", k), 32'(bus.gnt), 32'(1 << (k % 4)));
      chk($sformatf("rr_q%0d", k), 32'(bus.q), 32'(8'h10 + k % 4));
    end
    bus.req = '0;
    tick();

    // Pointer wrap: grant 3, then 0, then pointer sits at 1.
    bus.req = 4'b1000;
    tick();
    chk("wrap_gnt3", 32'(bus.gnt), 32'h8);
    bus.req = 4'b1001;
    tick();
    chk("wrap_gnt0", 32'(bus.gnt), 32'h1);
    chk("wrap_owner0", 32'(bus.owner), 0);
    bus.req = '0;
    tick();
    bus.req = 4'b1011;
    tick();
    chk("ptr_after_wrap", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    tick();

    // Idle hold after a write of 0x3E by requester 1.
    set_data(1, 8'h3E);
    bus.req = 4'b0010;
    tick();
    chk("hold_write_gnt", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("hold_gnt%0d", k), 32'(bus.gnt), 0);
      chk($sformatf("hold_q%0d", k), 32'(bus.q), 32'h3E);
      chk($sformatf("hold_owner%0d", k), 32'(bus.owner), 1);
      chk($sformatf("hold_qvalid%0d", k), 32'(bus.q_valid), 1);
    end

    // Mixed request patterns, checked by the model each cycle.
    for (int s = 0; s < 10; s++) begin
      bus.wdata = 32'hA0B1C2D3 ^ (32'(s) * 32'h01010101);
      bus.req   = pats[s];
      repeat (3) tick();
    end
    bus.req = '0;
    tick();

`ifdef ARB_LOCK_EN
    reset_pulse();
    for (int i = 0; i < N; i++) set_data(i, 8'(8'h20 + i));
    bus.req  = 4'b0010;
    bus.lock = 4'b0010;
    tick();
    chk("lock_enter_gnt", 32'(bus.gnt), 32'h2);
    bus.req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("locked_gnt%0d", k), 32'(bus.gnt), (k % 2 == 1) ? 32'h2 : 32'h0);
    end
    bus.lock = '0;
    tick();
    chk("unlock_gnt2", 32'(bus.gnt), 32'h4);
    tick();
    chk("unlock_gnt3", 32'(bus.gnt), 32'h8);
    tick();
    chk("unlock_gnt0", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    tick();
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
